// File: rtl/tap_smooth_fifo.sv
// ---------------------------------------------------------------------------
// tap_smooth_fifo
//
// Purpose:
//   Consumer for a 3-tap delay line. Each time the delay line advances, the
//   current tap window is smoothed with a rounded 1-2-1 kernel:
//     result = (tap0 + 2*tap1 + tap2 + 2) >> 2
//   The smoothing runs in a 2-stage pipeline. Results are buffered in a
//   small FIFO that drains through a valid/ready handshake.
//   The first two beats after reset are dropped because the delay line
//   still holds reset zeros in part of the window.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; clears all state
//   tap0       newest sample (first delay stage)
//   tap1       middle sample (second delay stage)
//   tap2       oldest sample (third delay stage)
//   in_valid   one-cycle strobe; the taps hold a new window this cycle
//   out_data   result at the head of the FIFO
//   out_valid  FIFO is non-empty
//   out_ready  consumer accepts out_data when out_valid && out_ready
//   count      FIFO occupancy, 0..DEPTH
//   overflow   sticky; a result was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module tap_smooth_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] tap0,
  input  logic [DW-1:0] tap1,
  input  logic [DW-1:0] tap2,
  input  logic          in_valid,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   count,
  output logic          overflow
);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;
  typedef logic [DW+1:0] sum_t;

  typedef enum logic [1:0] {
    FILL0 = 2'd0,
    FILL1 = 2'd1,
    RUN   = 2'd2
  } warm_state_t;

  localparam cnt_t FULL_COUNT = cnt_t'(DEPTH);

  warm_state_t state;
  warm_state_t state_next;

  logic          accept;
  logic          s1_valid;
  sum_t          s1_sum;
  sum_t          sum_next;
  sum_t          rounded;
  logic          s2_valid;
  logic [DW-1:0] s2_result;

  logic [DW-1:0] mem [DEPTH];
  ptr_t          wr_ptr;
  ptr_t          rd_ptr;
  logic          full;
  logic          push;
  logic          pop;
  logic          wr_en;

  // Warm-up state register. Counts the first two delay-line advances so
  // windows that still contain reset zeros are never smoothed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL0;
    end else begin
      state <= state_next;
    end
  end

  // Warm-up next-state logic. RUN is terminal until the next reset.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      FILL0: if (in_valid) state_next = FILL1;
      FILL1: if (in_valid) state_next = RUN;
      RUN:   accept = in_valid;
      default: state_next = FILL0;
    endcase
  end

  // The weighted sum fits in DW+2 bits (4*255 = 1020), and adding the
  // rounding constant 2 still fits (1022), so nothing saturates.
  always_comb begin
    sum_next = {2'b00, tap0} + {1'b0, tap1, 1'b0} + {2'b00, tap2};
    rounded  = s1_sum + sum_t'(2);
  end

  // Stage 1 registers the raw sum; stage 2 registers the rounded result.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sum    <= '0;
      s2_valid  <= 1'b0;
      s2_result <= '0;
    end else begin
      s1_valid  <= accept;
      s1_sum    <= sum_next;
      s2_valid  <= s1_valid;
      s2_result <= rounded[DW+1:2];
    end
  end

  // A push into a full FIFO is still honoured when a pop frees the head
  // slot on the same edge; only a push into a full FIFO with no pop drops.
  always_comb begin
    full  = (count == FULL_COUNT);
    push  = s2_valid;
    pop   = out_valid && out_ready;
    wr_en = push && (!full || pop);
  end

  // FIFO storage and pointers. Storage is cleared on reset so out_data
  // reads back zero until the first result is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= s2_result;
        wr_ptr      <= wr_ptr + ptr_t'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ptr_t'(1);
      end
    end
  end

  // Occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      case ({wr_en, pop})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // The head entry comes straight from registered storage, so a push
  // never reaches out_data in the same cycle.
  always_comb begin
    out_valid = (count != '0);
    out_data  = mem[rd_ptr];
  end

endmodule
